// File: rtl/mux_pkg.sv
// mux_pkg: selection-mode constants and width helper shared by the N:1 mux and its arbiter
package mux_pkg;
  localparam int MODE_SEL = 0;
  localparam int MODE_RR = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, ptr -> one-hot grant, gidx, any_grant), first request at or after ptr modulo N
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] gidx,
  output logic            any_grant
);
  always_comb begin
    grant = '0;
    gidx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_grant && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        gidx = SELW'((int'(ptr) + k) % N);
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_n1_rr.sv
// mux_n1_rr: N:1 valid/ready mux with one-entry output register; sel (MODE=0) or round-robin (MODE=1) picks in_valid/in_data into out_valid/out_data/out_chan, in_ready is combinational
module mux_n1_rr
  import mux_pkg::*;
#(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int MODE = MODE_RR,
  localparam int SELW = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);
  logic [N-1:0] grant;
  logic [SELW-1:0] gidx, rr_ptr_q, rr_ptr_d, out_chan_q, out_chan_d;
  logic any_grant, load_en, xfer, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_sel, out_data_q, out_data_d;
  if (MODE == MODE_RR) begin : g_rr
    rr_arbiter #(.N(N)) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .gidx      (gidx),
      .any_grant (any_grant)
    );
  end else begin : g_sel
    assign grant = (int'(sel) < N) ? ((N'(1) << sel) & in_valid) : '0;
    assign gidx = sel;
    assign any_grant = |grant;
  end
  assign load_en = !out_valid_q | out_ready;
  assign in_ready = grant & {N{load_en & !rst}};
  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N; i++) data_sel = data_sel | (grant[i] ? in_data[i*WIDTH +: WIDTH] : '0);
    xfer = any_grant & load_en;
    out_valid_d = load_en ? any_grant : out_valid_q;
    out_data_d = xfer ? data_sel : out_data_q;
    out_chan_d = xfer ? gidx : out_chan_q;
    rr_ptr_d = (MODE == MODE_RR && xfer) ? ((int'(gidx) == N - 1) ? '0 : gidx + 1'b1) : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
endmodule
